// File: rtl/sc_hs_ro_freq_meter.sv
// sc_hs_ro_freq_meter: counts rising edges of one selected ring-oscillator
// output over a programmable window of CLK cycles. Result is reported over a
// START/DONE handshake.
// Optional build macro SC_HS_RO_GLITCH_FILTER_EN: an edge counts only when
// the synchronised samples read 0,1,1 on three consecutive cycles, so any
// high pulse shorter than two CLK cycles is rejected.
module sc_hs_ro_freq_meter #(
  parameter int N_RO        = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (N_RO > 1) ? $clog2(N_RO) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [SEL_W-1:0] SEL,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic [N_RO-1:0]  RO_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             VALID,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, FIN} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               ovf_q, ovf_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic               cur;
  logic               edge_det;
  logic               accept;
  logic               win_zero;
  logic               tmr_zero;
  logic               meas_last;
`ifdef SC_HS_RO_GLITCH_FILTER_EN
  logic               prev2_q;
`endif

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign accept    = (state == IDLE) && START;
  assign win_zero  = (WINDOW == '0);
  assign tmr_zero  = (tmr_q == '0);
  assign meas_last = (state == MEASURE) && tmr_zero;
  assign cur       = sync_q[SYNC_STAGES-1];

`ifdef SC_HS_RO_GLITCH_FILTER_EN
  assign edge_det = ~prev2_q & prev_q & cur;
`else
  assign edge_det = cur & ~prev_q;
`endif

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; ARM and MEASURE both run down tmr_q to zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = win_zero ? FIN : ARM;
      ARM:     if (tmr_zero) state_nxt = MEASURE;
      MEASURE: if (tmr_zero) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    BUSY = (state == ARM) || (state == MEASURE);
    DONE = (state == FIN);
  end

  // Select and phase timer; ARM lasts SYNC_STAGES+1 cycles, MEASURE win_q cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_q <= '0;
      tmr_q <= '0;
    end else if (accept) begin
      sel_q <= SEL;
      tmr_q <= WIN_W'(SYNC_STAGES);
    end else if ((state == ARM) && tmr_zero) begin
      tmr_q <= win_q - WIN_W'(1);
    end else if (!tmr_zero) begin
      tmr_q <= tmr_q - WIN_W'(1);
    end
  end

  // Window length captured with the request; later WINDOW changes are ignored.
  always_ff @(posedge CLK) begin
    if (accept) win_q <= WINDOW;
  end

  // Synchroniser on the selected oscillator plus edge-detect history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
`ifdef SC_HS_RO_GLITCH_FILTER_EN
      prev2_q <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RO_IN[sel_q]};
      prev_q  <= cur;
`ifdef SC_HS_RO_GLITCH_FILTER_EN
      prev2_q <= prev_q;
`endif
    end
  end

  // Next counter value; only MEASURE cycles contribute edges.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if ((state == MEASURE) && edge_det) begin
      cnt_nxt = sat_inc(cnt_q);
      ovf_nxt = ovf_q | (&cnt_nxt);
    end
  end

  // Working edge counter, cleared on every accepted request.
  always_ff @(posedge CLK) begin
    if (accept) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Result registers load on entry to FIN so COUNT is current while DONE is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else if (accept && win_zero) begin
      COUNT <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b1;
    end else if (accept) begin
      VALID <= 1'b0;
    end else if (meas_last) begin
      COUNT <= cnt_nxt;
      OVF   <= ovf_nxt;
      VALID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_hs_ro_freq_meter.sv
// Bench for sc_hs_ro_freq_meter: directed runs push expected results into a
// queue per instance; monitors pop and compare whenever DONE is seen.
module tb_sc_hs_ro_freq_meter;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start16, start4;
  logic [1:0]  sel;
  logic [15:0] window;
  logic [3:0]  ro_in;

  logic        busy16, done16, valid16, ovf16;
  logic [15:0] count16;
  logic        busy4, done4, valid4, ovf4;
  logic [3:0]  count4;

  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q16[$];
  exp_t q4[$];

  sc_hs_ro_freq_meter dut (
    .CLK(clk), .RST(rst), .START(start16), .SEL(sel), .WINDOW(window),
    .RO_IN(ro_in), .BUSY(busy16), .DONE(done16), .VALID(valid16),
    .COUNT(count16), .OVF(ovf16)
  );

  sc_hs_ro_freq_meter #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .SEL(sel), .WINDOW(window),
    .RO_IN(ro_in), .BUSY(busy4), .DONE(done4), .VALID(valid4),
    .COUNT(count4), .OVF(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator stand-ins: [2] period-4 square, [1] 1-cycle pulse every 4,
  // [3] period-8 square, [0] stuck low.
  initial begin
    logic [2:0] ph;
    ph = 3'd0;
    ro_in = 4'b0000;
    forever begin
      @(negedge clk);
      ph = ph + 3'd1;
      ro_in = {ph[2], ph[1], (ph[1:0] == 2'b00), 1'b0};
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the default-width instance.
  always @(negedge clk) begin
    if (!rst && done16) begin
      if (q16.size() == 0) begin
        check("dut16_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("dut16_done_cycle", cyc, e.cyc);
        check("dut16_count", count16, e.cnt);
        check("dut16_ovf", ovf16, e.ovf);
        check("dut16_valid", valid16, 1);
        check("dut16_busy_at_done", busy16, 0);
      end
    end
  end

  // Monitor for the 4-bit counter instance.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("dut4_done_cycle", cyc, e.cyc);
        check("dut4_count", count4, e.cnt);
        check("dut4_ovf", ovf4, e.ovf);
        check("dut4_valid", valid4, 1);
      end
    end
  end

  // Issue one START pulse; when exp_valid, queue the hand-computed result.
  task automatic run(input bit wide, input int s, input int w,
                     input bit exp_valid, input int exp_cnt, input bit exp_ovf);
    exp_t e;
    @(negedge clk);
    sel    = 2'(s);
    window = 16'(w);
    if (wide) start16 = 1'b1;
    else      start4  = 1'b1;
    e.cyc = cyc + ((w == 0) ? 1 : (1 + 3 + w));
    e.cnt = exp_cnt;
    e.ovf = exp_ovf;
    if (exp_valid) begin
      if (wide) q16.push_back(e);
      else      q4.push_back(e);
    end
    @(negedge clk);
    start16 = 1'b0;
    start4  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    rst = 1'b1; start16 = 1'b0; start4 = 1'b0; sel = 2'd0; window = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy16, 0);
    check("reset_done", done16, 0);
    check("reset_valid", valid16, 0);
    check("reset_count", count16, 0);
    check("reset_ovf", ovf16, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Period-4 square on RO_IN[2], 100-cycle window.
    run(1, 2, 100, 1, 25, 0);
    check("busy_after_accept", busy16, 1);
    repeat (108) @(negedge clk);
    check("busy_after_done", busy16, 0);
    check("valid_sticky", valid16, 1);

    // Zero-length window finishes immediately without BUSY.
    run(1, 2, 0, 1, 0, 0);
    check("w0_busy_never", busy16, 0);
    repeat (3) @(negedge clk);
    check("w0_busy_idle", busy16, 0);

    // START re-pulsed with a different SEL while busy must be ignored.
    run(1, 2, 100, 1, 25, 0);
    repeat (8) @(negedge clk);
    sel = 2'd0; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    repeat (39) @(negedge clk);
    sel = 2'd0; window = 16'd3; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    repeat (60) @(negedge clk);
    check("repulse_idle", busy16, 0);

    // 4-bit counter saturates, then recovers on a shorter window.
    run(0, 2, 100, 1, 15, 1);
    repeat (108) @(negedge clk);
    run(0, 2, 20, 1, 5, 0);
    repeat (28) @(negedge clk);

    // Reset in the middle of MEASURE aborts without DONE.
    run(1, 2, 100, 0, 0, 0);
    repeat (42) @(negedge clk);
    check("abort_busy_before_rst", busy16, 1);
    rst = 1'b1;
    #1;
    check("abort_valid", valid16, 0);
    check("abort_busy", busy16, 0);
    check("abort_count", count16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(1, 2, 8, 1, 2, 0);
    repeat (16) @(negedge clk);

    // One-cycle pulses on RO_IN[1].
`ifdef SC_HS_RO_GLITCH_FILTER_EN
    run(1, 1, 100, 1, 0, 0);
`else
    run(1, 1, 100, 1, 25, 0);
`endif
    repeat (108) @(negedge clk);

    check("q16_drained", q16.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
